// File: rtl/ram512_pkg.sv
// Shared types and constants for the ram512 block engine.
// Widths, op codes, FSM states and the length clip helper.
package ram512_pkg;

  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 16;
  localparam int LEN_W     = ADDR_W + 1;
  localparam int RAM_DEPTH = 512;

  typedef enum logic [1:0] {
    OP_FILL     = 2'b00,
    OP_COPY     = 2'b01,
    OP_CHECK    = 2'b10,
    OP_FILL_INC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic [LEN_W-1:0] clip_len(
    input logic [LEN_W-1:0] l
  );
    if (l > LEN_W'(RAM_DEPTH)) begin
      return LEN_W'(RAM_DEPTH);
    end
    return l;
  endfunction

endpackage

// File: rtl/ram512.sv
// 512x16 RAM: synchronous write, combinational read of address.
// Ports: clk, address, data_in, write_enable -> data_out.
module ram512
  import ram512_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_enable,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem[address] <= data_in;
    end
  end

  assign data_out = mem[address];

endmodule

// File: rtl/ram512_addr_gen.sv
// Word index counter plus wrapping base+index address and last-word flag.
// Ports: clk, rst_n, clr, inc, base, len -> addr, idx, last.
module ram512_addr_gen
  import ram512_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0]  idx,
  output logic              last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + LEN_W'(1);
    end
  end

  // ADDR_W-bit sum wraps past 511 back to 0.
  assign addr = base + idx[ADDR_W-1:0];
  assign last = (idx == len - LEN_W'(1));

endmodule

// File: rtl/ram512_block_engine.sv
// Block command engine (FILL/FILL_INC/COPY/CHECK) mastering a ram512 port.
// Ports: start/op/src/dst/len/pattern in; busy/done/err_count/first_err_addr
// status out; mem_address/mem_wdata/mem_we out, mem_rdata in.
module ram512_block_engine
  import ram512_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state;
  op_e               op_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] pat_q;
  logic [DATA_W-1:0] hold_q;

  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  idx;
  logic              last;
  logic              inc;
  logic [LEN_W-1:0]  len_c;

  assign len_c = clip_len(len);

  // COPY advances the index only after its write half.
  assign inc = (state == ST_WR) ||
               (state == ST_RD && op_q == OP_CHECK);

  ram512_addr_gen u_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE),
    .inc   (inc),
    .base  ((state == ST_WR) ? dst_q : src_q),
    .len   (len_q),
    .addr  (addr),
    .idx   (idx),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      op_q           <= OP_FILL;
      src_q          <= '0;
      dst_q          <= '0;
      len_q          <= '0;
      pat_q          <= '0;
      hold_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op_q           <= op_e'(op);
            src_q          <= src;
            dst_q          <= dst;
            len_q          <= len_c;
            pat_q          <= pattern;
            err_count      <= '0;
            first_err_addr <= '0;
            if (len_c == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              busy <= 1'b1;
              if (op_e'(op) == OP_FILL ||
                  op_e'(op) == OP_FILL_INC) begin
                state <= ST_WR;
              end else begin
                state <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          if (op_q == OP_CHECK) begin
            if (mem_rdata != pat_q) begin
              if (err_count != LEN_W'(RAM_DEPTH)) begin
                err_count <= err_count + LEN_W'(1);
              end
              if (err_count == '0) begin
                first_err_addr <= addr;
              end
            end
            if (last) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            hold_q <= mem_rdata;
            state  <= ST_WR;
          end
        end
        ST_WR: begin
          if (last) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (op_q == OP_COPY) begin
            state <= ST_RD;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_we      = (state == ST_WR);
    mem_address = '0;
    mem_wdata   = '0;
    if (state == ST_RD || state == ST_WR) begin
      mem_address = addr;
    end
    if (state == ST_WR) begin
      unique case (1'b1)
        op_q == OP_COPY:     mem_wdata = hold_q;
        op_q == OP_FILL_INC: mem_wdata = pat_q + DATA_W'(idx);
        default:             mem_wdata = pat_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ram512_block_engine.sv
// Directed bench for ram512_block_engine with a ram512 memory model.
// Table of commands plus hand sequences for overlap, busy start and reset.
module tb_ram512_block_engine;
  import ram512_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [8:0]  src, dst;
  logic [9:0]  len;
  logic [15:0] pattern;
  logic        busy, done;
  logic [9:0]  err_count;
  logic [8:0]  first_err_addr;
  logic [8:0]  mem_address;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_we;

  int errors = 0;
  int checks = 0;

  logic [15:0] mdl [512];

  always #5 clk = ~clk;

  ram512_block_engine dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .op             (op),
    .src            (src),
    .dst            (dst),
    .len            (len),
    .pattern        (pattern),
    .busy           (busy),
    .done           (done),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_rdata      (mem_rdata)
  );

  ram512 u_ram (
    .clk          (clk),
    .address      (mem_address),
    .data_in      (mem_wdata),
    .write_enable (mem_we),
    .data_out     (mem_rdata)
  );

  typedef struct {
    logic [1:0]  op;
    logic [8:0]  src;
    logic [8:0]  dst;
    logic [9:0]  len;
    logic [15:0] pat;
    int          cyc;
    int          we;
    int          err;
    int          first;
  } vec_t;

  vec_t v [12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic apply_model(input logic [1:0] o, input logic [8:0] s,
                             input logic [8:0] d, input logic [9:0] l,
                             input logic [15:0] p);
    int n;
    n = (l > 10'd512) ? 512 : int'(l);
    for (int i = 0; i < n; i++) begin
      logic [8:0] wa, ra;
      wa = d + 9'(i);
      ra = s + 9'(i);
      case (o)
        2'b00: mdl[wa] = p;
        2'b11: mdl[wa] = p + 16'(i);
        2'b01: mdl[wa] = mdl[ra];
        default: ;
      endcase
    end
  endtask

  task automatic ram_cmp(input string nm);
    int bad;
    bad = 0;
    for (int a = 0; a < 512; a++) begin
      if (u_ram.mem[a] !== mdl[a]) bad++;
    end
    chk(nm, bad, 0);
  endtask

  // cyc = edges from the start-capture edge to the edge that raises done.
  task automatic run_cmd(input logic [1:0] o, input logic [8:0] s,
                         input logic [8:0] d, input logic [9:0] l,
                         input logic [15:0] p, input bit poke,
                         input bit hold_done, output int cyc,
                         output int we, output int dn,
                         output int bsy_done, output int bsy_post);
    cyc = -1; we = 0; dn = 0; bsy_done = -1; bsy_post = -1;
    @(negedge clk);
    op = o; src = s; dst = d; len = l; pattern = p; start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 1100; j++) begin
      @(negedge clk);
      start = poke && (j == 2);
      if (poke && j == 2) begin
        op = 2'b00; len = 10'd9; pattern = 16'hDEAD;
      end
      if (done) begin
        cyc = j - 1;
        dn++;
        bsy_done = int'(busy);
        break;
      end
      if (mem_we) we++;
    end
    if (hold_done) begin
      op = 2'b00; dst = 9'd400; len = 10'd5; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    if (done) dn++;
    bsy_post = int'(busy);
    if (mem_we) we++;
  endtask

  int cyc, we, dn, bd, bp;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; src = '0; dst = '0;
    len = '0; pattern = '0;
    for (int a = 0; a < 512; a++) mdl[a] = '0;

    v[0]  = '{2'b00, 9'd0,   9'd0,    10'd512, 16'h0000, 512, 512, 0, 0};
    v[1]  = '{2'b00, 9'd0,   9'h1F0,  10'd32,  16'hA5A5, 32,  32,  0, 0};
    v[2]  = '{2'b11, 9'd0,   9'd0,    10'd4,   16'hFFFE, 4,   4,   0, 0};
    v[3]  = '{2'b01, 9'd0,   9'd100,  10'd4,   16'h0000, 8,   4,   0, 0};
    v[4]  = '{2'b10, 9'd100, 9'd0,    10'd4,   16'h0000, 4,   0,   3, 100};
    v[5]  = '{2'b00, 9'd0,   9'd50,   10'd0,   16'h1111, 0,   0,   0, 0};
    v[6]  = '{2'b10, 9'd0,   9'd0,    10'd0,   16'h0000, 0,   0,   0, 0};
    v[7]  = '{2'b01, 9'd0,   9'd60,   10'd0,   16'h0000, 0,   0,   0, 0};
    v[8]  = '{2'b00, 9'd0,   9'd0,    10'd700, 16'h0000, 512, 512, 0, 0};
    v[9]  = '{2'b00, 9'd0,   9'd300,  10'd1,   16'h1234, 1,   1,   0, 0};
    v[10] = '{2'b10, 9'd0,   9'd0,    10'd512, 16'h0000, 512, 0,   1, 300};
    v[11] = '{2'b10, 9'd0,   9'd0,    10'd700, 16'h0000, 512, 0,   1, 300};

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_first", int'(first_err_addr), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_addr", int'(mem_address), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      run_cmd(v[k].op, v[k].src, v[k].dst, v[k].len, v[k].pat,
              1'b0, 1'b0, cyc, we, dn, bd, bp);
      apply_model(v[k].op, v[k].src, v[k].dst, v[k].len, v[k].pat);
      chk($sformatf("v%0d_done_edge", k), cyc, v[k].cyc);
      chk($sformatf("v%0d_writes", k), we, v[k].we);
      chk($sformatf("v%0d_done_pulses", k), dn, 1);
      chk($sformatf("v%0d_busy_in_done", k), bd, 0);
      chk($sformatf("v%0d_busy_after", k), bp, 0);
      chk($sformatf("v%0d_err_count", k), int'(err_count), v[k].err);
      chk($sformatf("v%0d_first_err", k), int'(first_err_addr), v[k].first);
      ram_cmp($sformatf("v%0d_ram_bad_words", k));
      if (k == 1) begin
        chk("fill_wrap_1f0", int'(u_ram.mem[9'h1F0]), 16'hA5A5);
        chk("fill_wrap_00f", int'(u_ram.mem[9'h00F]), 16'hA5A5);
        chk("fill_untouched_010", int'(u_ram.mem[9'h010]), 0);
      end
      if (k == 3) begin
        chk("copy_100", int'(u_ram.mem[100]), 16'hFFFE);
        chk("copy_101", int'(u_ram.mem[101]), 16'hFFFF);
        chk("copy_102", int'(u_ram.mem[102]), 16'h0000);
        chk("copy_103", int'(u_ram.mem[103]), 16'h0001);
      end
    end

    // Overlapping COPY with a start pulse while busy and one in DONE.
    run_cmd(2'b00, 9'd0, 9'd10, 10'd1, 16'h0007, 1'b0, 1'b0,
            cyc, we, dn, bd, bp);
    apply_model(2'b00, 9'd0, 9'd10, 10'd1, 16'h0007);
    run_cmd(2'b01, 9'd10, 9'd11, 10'd3, 16'h0000, 1'b1, 1'b1,
            cyc, we, dn, bd, bp);
    apply_model(2'b01, 9'd10, 9'd11, 10'd3, 16'h0000);
    chk("ovl_done_edge", cyc, 6);
    chk("ovl_writes", we, 3);
    chk("ovl_done_pulses", dn, 1);
    chk("ovl_start_in_done_busy", bp, 0);
    chk("ovl_ram_13", int'(u_ram.mem[13]), 7);
    chk("ovl_ram_14", int'(u_ram.mem[14]), 0);
    ram_cmp("ovl_ram_bad_words");
    @(negedge clk);
    chk("ovl_idle_busy", int'(busy), 0);

    // Reset asserted while word 5 of a 20-word FILL is on the port.
    @(negedge clk);
    op = 2'b00; dst = 9'd200; len = 10'd20; pattern = 16'hBEEF;
    start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_pre_we", int'(mem_we), 1);
    chk("abort_pre_addr", int'(mem_address), 205);
    rst_n = 1'b0;
    #1;
    chk("abort_we", int'(mem_we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_addr", int'(mem_address), 0);
    chk("abort_wdata", int'(mem_wdata), 0);
    dn = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst_n = 1'b1;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("abort_no_done", dn, 0);
    for (int i = 0; i < 5; i++) mdl[200 + i] = 16'hBEEF;
    ram_cmp("abort_ram_bad_words");

    run_cmd(2'b00, 9'd0, 9'd200, 10'd20, 16'h1357, 1'b0, 1'b0,
            cyc, we, dn, bd, bp);
    apply_model(2'b00, 9'd0, 9'd200, 10'd20, 16'h1357);
    chk("post_rst_done_edge", cyc, 20);
    chk("post_rst_writes", we, 20);
    chk("post_rst_done_pulses", dn, 1);
    ram_cmp("post_rst_ram_bad_words");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
